// File: rtl/led_event_arbiter_pkg.sv
// Shared definitions for the LED/status family of blocks.
//   led_state_t : pattern player states (IDLE=0, ON=1, OFF=2, GAP=3)
//   clog2_min1  : ceil(log2(v)) clamped to at least 1, for index widths
//   max_int     : larger of two integers, for sizing shared counters
package led_event_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_t;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_event_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin picker.
//   pending : request vector, bit k = requester k waiting
//   pointer : index with highest priority; search ascends from here and wraps
//   grant   : one-hot winner (all-zero when nothing is pending)
//   valid   : 1 when grant is non-zero
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // Two passes over constant indices: first the slots at or above the
  // pointer, then the wrapped slots below it.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!valid && pending[j] && (j >= int'(pointer))) begin
        grant[j] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!valid && pending[j] && (j < int'(pointer))) begin
        grant[j] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_event_arbiter.sv
// led_event_arbiter: shares one status LED among NUM_REQ event sources.
// Requests are queued, granted round-robin, and the owner is identified by
// (index+1) blinks of ON_CYCLES on / ON_CYCLES off followed by a GAP_CYCLES
// dark gap.
//   i_clk     : system clock, rising edge
//   i_rst     : asynchronous active-high reset
//   i_req     : single-cycle request pulses, synchronous to i_clk
//   o_led     : shared LED drive, 1 = on
//   o_busy    : high while a pattern (including its gap) plays
//   o_grant   : one-hot current owner, zero when idle
//   o_pending : queued requests not yet granted
module led_event_arbiter
  import led_event_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ON_CYCLES  = 5000000,
  parameter int GAP_CYCLES = 25000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic               o_led,
  output logic               o_busy,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [NUM_REQ-1:0] o_pending
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);
  localparam int BLK_W = $clog2(NUM_REQ + 1);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  led_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BLK_W-1:0]   blinks, blinks_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt, pending_nxt, clr;
  logic               led_nxt, busy_nxt;

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .pending (o_pending),
    .pointer (ptr),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_grant[j]) arb_idx = IDX_W'(j);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    blinks_nxt = blinks;
    owner_nxt  = owner;
    ptr_nxt    = ptr;
    grant_nxt  = o_grant;
    clr        = '0;

    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          state_nxt  = ON;
          cnt_nxt    = '0;
          blinks_nxt = BLK_W'(arb_idx) + BLK_W'(1);
          owner_nxt  = arb_idx;
          grant_nxt  = arb_grant;
          clr        = arb_grant;
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      OFF: begin
        if (cnt == ON_LAST) begin
          cnt_nxt    = '0;
          blinks_nxt = blinks - BLK_W'(1);
          state_nxt  = (blinks == BLK_W'(1)) ? GAP : ON;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          grant_nxt = '0;
          ptr_nxt   = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new pulse overrides the clear of the bit being granted.
    pending_nxt = (o_pending & ~clr) | i_req;
    led_nxt     = (state_nxt == ON);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      blinks    <= '0;
      owner     <= '0;
      ptr       <= '0;
      o_grant   <= '0;
      o_pending <= '0;
      o_led     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      blinks    <= blinks_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      o_grant   <= grant_nxt;
      o_pending <= pending_nxt;
      o_led     <= led_nxt;
      o_busy    <= busy_nxt;
    end
  end

endmodule
